m_booth_radix4_seq: RTL and testbench
=====================================

// Module: m_booth_radix4_seq
// PURPOSE
//  Sequential radix-4 (modified Booth) signed multiplier controller. Initiator side of the
//  pulse-handshake 2's-complement unit: sends the sign-extended multiplicand once, receives
//  -A, then accumulates N/2 Booth partial products (one per cycle) into a 2N-bit product.
//  Sits between the operand source and the result consumer; the complement unit is external.
// PARAMETERS
//  N      4   operand width (signed, must be even, >=2); complement interface is N+1 bits
//  TOUT   15  max cycles spent in WAIT_NEG for tog_resp_pulse before error abort
// PORTS
//  clock           in   1     rising-edge clock
//  reset           in   1     synchronous, active-high
//  in_a            in   N     multiplicand A (signed)
//  in_b            in   N     multiplier B (signed)
//  in_valid_pulse  in   1     1-cycle start strobe; A/B sampled on same edge
//  busy            out  1     operation in progress
//  out_product     out  2N    signed A*B, held until next result/reset
//  out_valid_pulse out  1     1-cycle strobe: out_product valid
//  out_err_pulse   out  1     1-cycle strobe: complement unit timed out
//  tog_req_data    out  N+1   sign-extended A sent to complement unit
//  tog_req_pulse   out  1     1-cycle request strobe
//  tog_busy        in   1     complement unit busy; no request issued while high
//  tog_resp_data   in   N+1   -A from complement unit
//  tog_resp_pulse  in   1     1-cycle response strobe
// BEHAVIOUR
//  Reset: state IDLE; busy, out_product, out_valid_pulse, out_err_pulse, tog_req_data,
//   tog_req_pulse, acc, step counter, timeout counter all 0. Reset mid-op aborts, no strobe.
//  All strobe outputs default 0 each cycle (pulse only, registered).
//  FSM:
//   IDLE: on in_valid_pulse: latch A_x={A[N-1],A}, B; busy<=1; acc<=0 -> REQ.
//   REQ: if !tog_busy: tog_req_data<=A_x, tog_req_pulse<=1, tout<=0 -> WAIT_NEG; else stay.
//   WAIT_NEG: on tog_resp_pulse: negA<=tog_resp_data, step<=0 -> ACCUM.
//    else tout++; at tout==TOUT-1: out_err_pulse<=1, busy<=0, out_product<=0 -> IDLE.
//   ACCUM: group g={B[2i+1],B[2i],B[2i-1]}, B[-1]=0, i=step. PP (N+2 bits, sign-ext A/negA):
//    000,111->0; 001,010->+A; 011->+2A; 100->-2A (negA<<1); 101,110->-A.
//    acc <= acc + (sext2N(PP) << 2i), 2N-bit wrap arithmetic; step==N/2-1 -> DONE.
//   DONE: out_product<=acc, out_valid_pulse<=1, busy<=0 -> IDLE.
//   default/illegal state -> IDLE.
//  Latency: start edge -> REQ next cycle; request issued first cycle tog_busy low;
//   response edge -> N/2 ACCUM cycles + 1 DONE cycle -> out_valid_pulse.
//  busy rises the cycle after start is sampled; falls on same edge as out_valid/err pulse.
//  in_valid_pulse outside IDLE ignored (operands not re-sampled).
//  tog_resp_pulse outside WAIT_NEG ignored; response in same cycle as tout limit wins.
//  -A for A=-2^(N-1) is +2^(N-1), representable in N+1 bits; product of two minimums
//   (+2^(2N-2)) fits 2N signed bits.
//  Exactly one tog_req_pulse per accepted operation.
// TESTING (bench responder: invert, +1, 3-cycle latency, busy while working; N=4)
//  1. A=3,B=5 -> one tog_req_pulse data 0x03, resp 0x1D; out_product 0x0F, out_valid 1 cycle.
//  2. A=-8,B=-8 -> req data 0x18, resp 0x08; out_product 0x40. A=-8,B=7 -> 0xC8.
//  3. A=7,B=-1 -> 0xF9; A=0,B=-5 -> 0x00; exhaustive 256 pairs match signed A*B.
//  4. tog_busy held high 5 cycles after start -> no req until low; result still correct.
//  5. responder silent -> out_err_pulse exactly 15 cycles after req, busy 0, out_product 0x00.
//  6. reset during ACCUM -> no strobes, busy 0 next cycle; next op A=2,B=3 -> 0x06;
//     in_valid_pulse while busy -> ignored, result from first operands only.

Source files
------------

// File: rtl/m_booth_radix4_seq.sv
// Sequential radix-4 Booth signed multiplier. Obtains -A once from an external
// complement unit over a pulse handshake, then adds one partial product per cycle.
module m_booth_radix4_seq #(
    parameter int unsigned N    = 4,
    parameter int unsigned TOUT = 15
) (
    input  logic           clock,
    input  logic           reset,
    input  logic [N-1:0]   in_a,
    input  logic [N-1:0]   in_b,
    input  logic           in_valid_pulse,
    output logic           busy,
    output logic [2*N-1:0] out_product,
    output logic           out_valid_pulse,
    output logic           out_err_pulse,
    output logic [N:0]     tog_req_data,
    output logic           tog_req_pulse,
    input  logic           tog_busy,
    input  logic [N:0]     tog_resp_data,
    input  logic           tog_resp_pulse
);

    localparam int unsigned SW = (N / 2 > 1) ? $clog2(N / 2) : 1;
    localparam int unsigned TW = (TOUT > 1) ? $clog2(TOUT) : 1;
    localparam logic [SW-1:0] LastStep = SW'(N / 2 - 1);
    localparam logic [TW-1:0] ToutLast = TW'(TOUT - 1);

    typedef enum logic [2:0] {
        StIdle,
        StReq,
        StWaitNeg,
        StAccum,
        StDone
    } state_e;

    state_e         state_q, state_d;
    logic [N:0]     a_x_q, a_x_d;
    logic [N-1:0]   b_q, b_d;
    logic [N:0]     neg_a_q, neg_a_d;
    logic [2*N-1:0] acc_q, acc_d;
    logic [SW-1:0]  step_q, step_d;
    logic [TW-1:0]  tout_q, tout_d;
    logic           busy_q, busy_d;
    logic [2*N-1:0] out_product_q, out_product_d;
    logic           out_valid_q, out_valid_d;
    logic           out_err_q, out_err_d;
    logic [N:0]     req_data_q, req_data_d;
    logic           req_pulse_q, req_pulse_d;

    logic [2:0]     grp;
    logic [N+1:0]   pp;
    logic [2*N-1:0] pp_ext;
    logic [2*N-1:0] pp_shift;

    // Booth digit select; B is extended with an implicit 0 below bit 0.
    always_comb begin
        grp = 3'({b_q, 1'b0} >> {step_q, 1'b0});
        case (grp)
            3'b001, 3'b010: pp = {a_x_q[N], a_x_q};
            3'b011:         pp = {a_x_q, 1'b0};
            3'b100:         pp = {neg_a_q, 1'b0};
            3'b101, 3'b110: pp = {neg_a_q[N], neg_a_q};
            default:        pp = '0;
        endcase
        pp_ext   = (2 * N)'($signed(pp));
        pp_shift = pp_ext << {step_q, 1'b0};
    end

    always_comb begin
        state_d       = state_q;
        a_x_d         = a_x_q;
        b_d           = b_q;
        neg_a_d       = neg_a_q;
        acc_d         = acc_q;
        step_d        = step_q;
        tout_d        = tout_q;
        busy_d        = busy_q;
        out_product_d = out_product_q;
        out_valid_d   = 1'b0;
        out_err_d     = 1'b0;
        req_data_d    = req_data_q;
        req_pulse_d   = 1'b0;

        case (state_q)
            StIdle: begin
                if (in_valid_pulse) begin
                    a_x_d   = {in_a[N-1], in_a};
                    b_d     = in_b;
                    busy_d  = 1'b1;
                    acc_d   = '0;
                    state_d = StReq;
                end
            end
            StReq: begin
                if (!tog_busy) begin
                    req_data_d  = a_x_q;
                    req_pulse_d = 1'b1;
                    tout_d      = '0;
                    state_d     = StWaitNeg;
                end
            end
            StWaitNeg: begin
                // A response arriving on the timeout cycle still wins.
                if (tog_resp_pulse) begin
                    neg_a_d = tog_resp_data;
                    step_d  = '0;
                    state_d = StAccum;
                end else if (tout_q == ToutLast) begin
                    out_err_d     = 1'b1;
                    busy_d        = 1'b0;
                    out_product_d = '0;
                    state_d       = StIdle;
                end else begin
                    tout_d = tout_q + 1'b1;
                end
            end
            StAccum: begin
                acc_d = acc_q + pp_shift;
                if (step_q == LastStep) begin
                    state_d = StDone;
                end else begin
                    step_d = step_q + 1'b1;
                end
            end
            StDone: begin
                out_product_d = acc_q;
                out_valid_d   = 1'b1;
                busy_d        = 1'b0;
                state_d       = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q       <= StIdle;
            a_x_q         <= '0;
            b_q           <= '0;
            neg_a_q       <= '0;
            acc_q         <= '0;
            step_q        <= '0;
            tout_q        <= '0;
            busy_q        <= 1'b0;
            out_product_q <= '0;
            out_valid_q   <= 1'b0;
            out_err_q     <= 1'b0;
            req_data_q    <= '0;
            req_pulse_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            a_x_q         <= a_x_d;
            b_q           <= b_d;
            neg_a_q       <= neg_a_d;
            acc_q         <= acc_d;
            step_q        <= step_d;
            tout_q        <= tout_d;
            busy_q        <= busy_d;
            out_product_q <= out_product_d;
            out_valid_q   <= out_valid_d;
            out_err_q     <= out_err_d;
            req_data_q    <= req_data_d;
            req_pulse_q   <= req_pulse_d;
        end
    end

    assign busy            = busy_q;
    assign out_product     = out_product_q;
    assign out_valid_pulse = out_valid_q;
    assign out_err_pulse   = out_err_q;
    assign tog_req_data    = req_data_q;
    assign tog_req_pulse   = req_pulse_q;

endmodule

// File: tb/tb_m_booth_radix4_seq.sv
// Bench for m_booth_radix4_seq: drives operations through an in-bench complement
// responder and compares against plain signed multiplication.
module tb_m_booth_radix4_seq;

    localparam int N = 4;

    logic           clock = 1'b0;
    logic           reset;
    logic [N-1:0]   in_a, in_b;
    logic           in_valid_pulse;
    logic           busy;
    logic [2*N-1:0] out_product;
    logic           out_valid_pulse, out_err_pulse;
    logic [N:0]     tog_req_data;
    logic           tog_req_pulse;
    logic           tog_busy;
    logic [N:0]     tog_resp_data;
    logic           tog_resp_pulse;

    int n_cmp = 0;
    int n_bad = 0;

    m_booth_radix4_seq #(.N(4), .TOUT(15)) dut (
        .clock          (clock),
        .reset          (reset),
        .in_a           (in_a),
        .in_b           (in_b),
        .in_valid_pulse (in_valid_pulse),
        .busy           (busy),
        .out_product    (out_product),
        .out_valid_pulse(out_valid_pulse),
        .out_err_pulse  (out_err_pulse),
        .tog_req_data   (tog_req_data),
        .tog_req_pulse  (tog_req_pulse),
        .tog_busy       (tog_busy),
        .tog_resp_data  (tog_resp_data),
        .tog_resp_pulse (tog_resp_pulse)
    );

    always #5 clock = ~clock;

    function automatic logic [7:0] ref_mul(input logic [3:0] a, input logic [3:0] b);
        int pa, pb;
        pa = $signed(a);
        pb = $signed(b);
        return 8'(pa * pb);
    endfunction

    // One operation: start, optional busy hold, responder (invert+1, 3-cycle latency),
    // optional stray start at ign_at and reset at reset_at. Observations returned.
    task automatic do_op(input logic [3:0] a, input logic [3:0] b, input int busy_cycles,
                         input bit respond, input int ign_at, input int reset_at,
                         output logic [7:0] prod, output bit got_valid, output bit got_err,
                         output int strobes, output int req_count, output logic [4:0] req_data,
                         output int err_delay, output int valid_lat,
                         output bit req_while_busy, output bit busy_bad);
        int cyc, req_cyc, resp_at, post;
        bit prev_busy_in, rst_seen;
        cyc = 0; req_cyc = -1; resp_at = -1; post = -1; rst_seen = 0;
        prod = '0; got_valid = 0; got_err = 0; strobes = 0; req_count = 0; req_data = '0;
        err_delay = -1; valid_lat = -1; req_while_busy = 0; busy_bad = 0;
        @(negedge clock);
        in_a = a; in_b = b; in_valid_pulse = 1'b1;
        tog_busy = (busy_cycles > 0);
        prev_busy_in = tog_busy;
        while (cyc < 60 && post != 0) begin
            @(negedge clock);
            cyc++;
            if (post > 0) post--;
            if (tog_req_pulse) begin
                req_count++;
                req_data = tog_req_data;
                req_cyc = cyc;
                if (prev_busy_in) req_while_busy = 1;
                if (respond && resp_at < 0) resp_at = cyc + 3;
            end
            if (out_valid_pulse || out_err_pulse) begin
                strobes++;
                if (post < 0) begin
                    got_valid = out_valid_pulse;
                    got_err = out_err_pulse;
                    prod = out_product;
                    err_delay = cyc - req_cyc;
                    valid_lat = cyc - resp_at;
                    post = 3;
                    if (busy) busy_bad = 1;
                end
            end else if (post < 0 && !rst_seen && !busy) begin
                busy_bad = 1;
            end
            if (rst_seen && busy) busy_bad = 1;
            in_a = ~a;
            in_b = ~b;
            in_valid_pulse = (cyc == ign_at);
            reset = (cyc == reset_at);
            if (cyc == reset_at) rst_seen = 1;
            tog_resp_pulse = (cyc == resp_at);
            tog_resp_data = ~req_data + 5'd1;
            tog_busy = (cyc < busy_cycles) || (resp_at > 0 && cyc < resp_at);
            prev_busy_in = tog_busy;
        end
        in_valid_pulse = 1'b0;
        reset = 1'b0;
        tog_resp_pulse = 1'b0;
        tog_busy = 1'b0;
    endtask

    task automatic test_reset;
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        @(negedge clock);
        reset = 1'b0;
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b want 0", busy); end
        n_cmp++; if (out_product !== 8'h00) begin n_bad++; $display("FAIL reset_product: got %h want 00", out_product); end
        n_cmp++; if (out_valid_pulse !== 1'b0) begin n_bad++; $display("FAIL reset_valid: got %b want 0", out_valid_pulse); end
        n_cmp++; if (out_err_pulse !== 1'b0) begin n_bad++; $display("FAIL reset_err: got %b want 0", out_err_pulse); end
        n_cmp++; if (tog_req_pulse !== 1'b0) begin n_bad++; $display("FAIL reset_req_pulse: got %b want 0", tog_req_pulse); end
        n_cmp++; if (tog_req_data !== 5'h00) begin n_bad++; $display("FAIL reset_req_data: got %h want 00", tog_req_data); end
    endtask

    task automatic test_directed;
        logic [3:0] ta [5] = '{4'd3, 4'h8, 4'h8, 4'd7, 4'd0};
        logic [3:0] tb [5] = '{4'd5, 4'h8, 4'd7, 4'hF, 4'hB};
        logic [7:0] p; bit gv, ge, rwb, bb; int st, rc, ed, vl; logic [4:0] rd;
        for (int i = 0; i < 5; i++) begin
            do_op(ta[i], tb[i], 0, 1, 0, 0, p, gv, ge, st, rc, rd, ed, vl, rwb, bb);
            n_cmp++; if (p !== ref_mul(ta[i], tb[i])) begin n_bad++;
                $display("FAIL dir_product[%0d]: got %h want %h", i, p, ref_mul(ta[i], tb[i])); end
            n_cmp++; if (rd !== {ta[i][3], ta[i]}) begin n_bad++;
                $display("FAIL dir_req_data[%0d]: got %h want %h", i, rd, {ta[i][3], ta[i]}); end
            n_cmp++; if (rc !== 1) begin n_bad++; $display("FAIL dir_req_count[%0d]: got %0d want 1", i, rc); end
            n_cmp++; if (gv !== 1'b1 || ge !== 1'b0 || st !== 1) begin n_bad++;
                $display("FAIL dir_strobe[%0d]: got valid=%b err=%b cycles=%0d want 1/0/1", i, gv, ge, st); end
            n_cmp++; if (vl !== N / 2 + 2) begin n_bad++;
                $display("FAIL dir_latency[%0d]: got %0d want %0d", i, vl, N / 2 + 2); end
            n_cmp++; if (bb !== 1'b0) begin n_bad++; $display("FAIL dir_busy[%0d]: got bad=%b want 0", i, bb); end
        end
    endtask

    task automatic test_exhaustive;
        logic [7:0] p; bit gv, ge, rwb, bb; int st, rc, ed, vl; logic [4:0] rd;
        logic [3:0] a, b;
        for (int i = 0; i < 256; i++) begin
            a = 4'(i >> 4);
            b = 4'(i);
            do_op(a, b, 0, 1, 0, 0, p, gv, ge, st, rc, rd, ed, vl, rwb, bb);
            n_cmp++; if (p !== ref_mul(a, b) || gv !== 1'b1 || rc !== 1) begin n_bad++;
                $display("FAIL exh a=%h b=%h: got %h valid=%b reqs=%0d want %h/1/1",
                         a, b, p, gv, rc, ref_mul(a, b)); end
        end
    endtask

    task automatic test_tog_busy;
        logic [7:0] p; bit gv, ge, rwb, bb; int st, rc, ed, vl; logic [4:0] rd;
        logic [3:0] a, b;
        do_op(4'd6, 4'hD, 5, 1, 0, 0, p, gv, ge, st, rc, rd, ed, vl, rwb, bb);
        n_cmp++; if (rwb !== 1'b0) begin n_bad++; $display("FAIL busy_hold_req: got req_while_busy=%b want 0", rwb); end
        n_cmp++; if (p !== ref_mul(4'd6, 4'hD) || gv !== 1'b1) begin n_bad++;
            $display("FAIL busy_hold_product: got %h valid=%b want %h/1", p, gv, ref_mul(4'd6, 4'hD)); end
        for (int i = 0; i < 40; i++) begin
            a = 4'($urandom);
            b = 4'($urandom);
            do_op(a, b, int'($urandom_range(0, 4)), 1, 0, 0, p, gv, ge, st, rc, rd, ed, vl, rwb, bb);
            n_cmp++; if (p !== ref_mul(a, b) || gv !== 1'b1 || rwb !== 1'b0 || rc !== 1) begin n_bad++;
                $display("FAIL rand a=%h b=%h: got %h valid=%b rwb=%b reqs=%0d want %h/1/0/1",
                         a, b, p, gv, rwb, rc, ref_mul(a, b)); end
        end
    endtask

    task automatic test_timeout;
        logic [7:0] p; bit gv, ge, rwb, bb; int st, rc, ed, vl; logic [4:0] rd;
        do_op(4'd5, 4'd3, 0, 0, 0, 0, p, gv, ge, st, rc, rd, ed, vl, rwb, bb);
        n_cmp++; if (ge !== 1'b1 || gv !== 1'b0 || st !== 1) begin n_bad++;
            $display("FAIL timeout_strobe: got err=%b valid=%b cycles=%0d want 1/0/1", ge, gv, st); end
        n_cmp++; if (ed !== 15) begin n_bad++; $display("FAIL timeout_delay: got %0d want 15", ed); end
        n_cmp++; if (p !== 8'h00) begin n_bad++; $display("FAIL timeout_product: got %h want 00", p); end
        n_cmp++; if (bb !== 1'b0) begin n_bad++; $display("FAIL timeout_busy: got bad=%b want 0", bb); end
        n_cmp++; if (rc !== 1) begin n_bad++; $display("FAIL timeout_req_count: got %0d want 1", rc); end
    endtask

    task automatic test_reset_mid_and_ignore;
        logic [7:0] p; bit gv, ge, rwb, bb; int st, rc, ed, vl; logic [4:0] rd;
        do_op(4'd5, 4'hD, 0, 1, 0, 6, p, gv, ge, st, rc, rd, ed, vl, rwb, bb);
        n_cmp++; if (st !== 0) begin n_bad++; $display("FAIL midreset_strobes: got %0d want 0", st); end
        n_cmp++; if (bb !== 1'b0) begin n_bad++; $display("FAIL midreset_busy: got bad=%b want 0", bb); end
        n_cmp++; if (out_product !== 8'h00) begin n_bad++;
            $display("FAIL midreset_product: got %h want 00", out_product); end
        do_op(4'd2, 4'd3, 0, 1, 3, 0, p, gv, ge, st, rc, rd, ed, vl, rwb, bb);
        n_cmp++; if (p !== 8'h06 || gv !== 1'b1) begin n_bad++;
            $display("FAIL ignore_start_product: got %h valid=%b want 06/1", p, gv); end
        n_cmp++; if (rc !== 1 || st !== 1) begin n_bad++;
            $display("FAIL ignore_start_count: got reqs=%0d strobes=%0d want 1/1", rc, st); end
    endtask

    initial begin
        reset = 1'b1; in_a = '0; in_b = '0; in_valid_pulse = 1'b0;
        tog_busy = 1'b0; tog_resp_data = '0; tog_resp_pulse = 1'b0;
        repeat (2) @(negedge clock);
        reset = 1'b0;
        test_directed();
        test_reset();
        test_exhaustive();
        test_tog_busy();
        test_timeout();
        test_reset_mid_and_ignore();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
